// File: rtl/fibo_index_finder_if.sv
// Start/Ready handshake bundle for the Fibonacci index finder.
// The master drives the seeds, target and Start; the slave returns status and the step count.
interface fibo_index_finder_if #(
  parameter int R_size = 16,
  parameter int C_size = 8
);
  logic [R_size-1:0] data1;
  logic [R_size-1:0] data2;
  logic [R_size-1:0] target;
  logic              Start;
  logic              Ready;
  logic              done;
  logic              found;
  logic              overflow;
  logic [C_size-1:0] count;

  modport master (
    output data1, data2, target, Start,
    input  Ready, done, found, overflow, count
  );

  modport slave (
    input  data1, data2, target, Start,
    output Ready, done, found, overflow, count
  );
endinterface

// File: rtl/fibo_index_finder.sv
// Searches for the smallest Fibonacci step n at which R2 equals the target.
// The controller FSM owns the status outputs; the datapath owns R1, R2, the target copy and N.
module fibo_index_finder #(
  parameter int R_size = 16,
  parameter int C_size = 8
) (
  input logic              clock,
  input logic              reset,
  fibo_index_finder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CMP, STEP} state_t;

  localparam logic [C_size-1:0] MAX_N = '1;

  state_t            state;
  logic [R_size-1:0] r1;
  logic [R_size-1:0] r2;
  logic [R_size-1:0] t;
  logic [C_size-1:0] n;
  logic [R_size:0]   sum;
  logic              done_q;
  logic              found_q;
  logic              overflow_q;
  logic [C_size-1:0] count_q;
  logic              load;
  logic              advance;

  assign sum     = {1'b0, r1} + {1'b0, r2};
  assign load    = (state == IDLE) && bus.Start;
  assign advance = (state == STEP) && !sum[R_size];

  // Controller: the status outputs are registered and stay put until the next accepted Start.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      done_q     <= 1'b0;
      found_q    <= 1'b0;
      overflow_q <= 1'b0;
      count_q    <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.Start) begin
            found_q    <= 1'b0;
            overflow_q <= 1'b0;
            count_q    <= '0;
            state      <= CMP;
          end
        end
        CMP: begin
          // A match wins over the saturation check, so a tie at MAX_N still reports found.
          if (r2 == t) begin
            found_q <= 1'b1;
            count_q <= n;
            done_q  <= 1'b1;
            state   <= IDLE;
          end else if ((r2 > t) || (n == MAX_N)) begin
            found_q <= 1'b0;
            count_q <= n;
            done_q  <= 1'b1;
            state   <= IDLE;
          end else begin
            state <= STEP;
          end
        end
        STEP: begin
          if (sum[R_size]) begin
            overflow_q <= 1'b1;
            found_q    <= 1'b0;
            count_q    <= n;
            done_q     <= 1'b1;
            state      <= IDLE;
          end else begin
            state <= CMP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath: a carry-out leaves R1/R2 frozen so the last valid pair is retained.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r1 <= '0;
      r2 <= '0;
      t  <= '0;
      n  <= '0;
    end else if (load) begin
      r1 <= bus.data1;
      r2 <= bus.data2;
      t  <= bus.target;
      n  <= '0;
    end else if (advance) begin
      r1 <= r2;
      r2 <= sum[R_size-1:0];
      n  <= n + 1'b1;
    end
  end

  assign bus.Ready    = (state == IDLE);
  assign bus.done     = done_q;
  assign bus.found    = found_q;
  assign bus.overflow = overflow_q;
  assign bus.count    = count_q;

endmodule

// File: tb/tb_fibo_index_finder.sv
// Scoreboard bench for fibo_index_finder: stimulus pushes expected results, a monitor
// pops and compares them whenever done pulses, including the edge on which it arrived.
module tb_fibo_index_finder;

  localparam int R_size = 16;
  localparam int C_size = 8;

  typedef struct {
    logic              found;
    logic              overflow;
    logic [C_size-1:0] count;
    int                doneEdge;
  } expect_t;

  logic clock;
  logic reset;
  int   edgeCount;
  int   totalChecks;
  int   passCount;
  expect_t sbQueue[$];

  fibo_index_finder_if #(.R_size(R_size), .C_size(C_size)) bus ();

  fibo_index_finder #(.R_size(R_size), .C_size(C_size)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) edgeCount = edgeCount + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    totalChecks = totalChecks + 1;
    if (actual === expected) begin
      passCount = passCount + 1;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic pushExp(input logic f, input logic o, input logic [C_size-1:0] c, input int e);
    expect_t x;
    x.found    = f;
    x.overflow = o;
    x.count    = c;
    x.doneEdge = e;
    sbQueue.push_back(x);
  endtask

  // Loads one search on the next edge and records the expected result and done edge.
  task automatic applyStimulus(input logic [R_size-1:0] d1, input logic [R_size-1:0] d2,
                               input logic [R_size-1:0] tg, input logic f, input logic o,
                               input logic [C_size-1:0] c, input int latency);
    @(negedge clock);
    bus.data1  = d1;
    bus.data2  = d2;
    bus.target = tg;
    bus.Start  = 1'b1;
    @(posedge clock);
    #1;
    pushExp(f, o, c, edgeCount + latency);
    @(negedge clock);
    bus.Start  = 1'b0;
    bus.data1  = 16'hDEAD;
    bus.data2  = 16'hBEEF;
    bus.target = 16'h1234;
  endtask

  task automatic waitIdle(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (sbQueue.size() == 0 && bus.Ready) break;
      @(negedge clock);
    end
    checkOutput("drain", sbQueue.size(), 0);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (reset && bus.done) begin
      if (sbQueue.size() == 0) begin
        checkOutput("unexpected_done", 1, 0);
      end else begin
        expect_t x;
        x = sbQueue.pop_front();
        checkOutput("found", bus.found, x.found);
        checkOutput("overflow", bus.overflow, x.overflow);
        checkOutput("count", bus.count, x.count);
        checkOutput("done_edge", edgeCount, x.doneEdge);
        checkOutput("ready_at_done", bus.Ready, 1);
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    edgeCount   = 0;
    totalChecks = 0;
    passCount   = 0;
    reset       = 1'b0;
    bus.data1   = '0;
    bus.data2   = '0;
    bus.target  = '0;
    bus.Start   = 1'b0;

    repeat (3) @(negedge clock);
    checkOutput("rst_ready", bus.Ready, 1);
    checkOutput("rst_done", bus.done, 0);
    checkOutput("rst_found", bus.found, 0);
    checkOutput("rst_overflow", bus.overflow, 0);
    checkOutput("rst_count", bus.count, 0);
    reset = 1'b1;
    @(negedge clock);

    // Match at n=6: R2 runs 5,9,14,23,37,60,97.
    applyStimulus(16'd4, 16'd5, 16'd97, 1'b1, 1'b0, 8'd6, 13);
    waitIdle(40);

    // Immediate match at n=0.
    applyStimulus(16'd4, 16'd5, 16'd5, 1'b1, 1'b0, 8'd0, 1);
    waitIdle(10);

    // R2=60 overshoots 50 at n=5.
    applyStimulus(16'd4, 16'd5, 16'd50, 1'b0, 1'b0, 8'd5, 11);
    waitIdle(40);

    // Carry-out on the first STEP.
    applyStimulus(16'h8000, 16'h8000, 16'hFFFF, 1'b0, 1'b1, 8'd0, 2);
    waitIdle(10);
    checkOutput("overflow_held", bus.overflow, 1);

    // n=0 match reported even though data1 > data2.
    applyStimulus(16'd9, 16'd3, 16'd3, 1'b1, 1'b0, 8'd0, 1);
    waitIdle(10);

    // Step counter saturation with a mid-search Start that must be ignored.
    applyStimulus(16'd0, 16'd0, 16'd1, 1'b0, 1'b0, 8'd255, 511);
    repeat (100) @(negedge clock);
    checkOutput("busy_ready", bus.Ready, 0);
    bus.data1  = 16'd4;
    bus.data2  = 16'd5;
    bus.target = 16'd5;
    bus.Start  = 1'b1;
    @(negedge clock);
    bus.Start  = 1'b0;
    waitIdle(600);

    // Start held through the done cycle launches a second search right away.
    @(negedge clock);
    bus.data1  = 16'd4;
    bus.data2  = 16'd5;
    bus.target = 16'd5;
    bus.Start  = 1'b1;
    @(posedge clock);
    #1;
    pushExp(1'b1, 1'b0, 8'd0, edgeCount + 1);
    @(posedge clock);
    @(posedge clock);
    #1;
    pushExp(1'b1, 1'b0, 8'd0, edgeCount + 1);
    @(negedge clock);
    bus.Start = 1'b0;
    waitIdle(10);

    // Reset asserted five edges into a search aborts it with no done pulse.
    applyStimulus(16'd4, 16'd5, 16'd97, 1'b1, 1'b0, 8'd6, 13);
    repeat (5) @(posedge clock);
    #1;
    reset = 1'b0;
    sbQueue.delete();
    #1;
    checkOutput("abort_ready", bus.Ready, 1);
    checkOutput("abort_done", bus.done, 0);
    checkOutput("abort_found", bus.found, 0);
    checkOutput("abort_overflow", bus.overflow, 0);
    checkOutput("abort_count", bus.count, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checkOutput("abort_no_done", bus.done, 0);
    end
    reset = 1'b1;
    @(negedge clock);
    applyStimulus(16'd4, 16'd5, 16'd97, 1'b1, 1'b0, 8'd6, 13);
    waitIdle(40);

    repeat (3) @(negedge clock);
    checkOutput("final_done_low", bus.done, 0);

    $display("%0d/%0d checks passed", passCount, totalChecks);
    $finish;
  end

endmodule
